// File: rtl/gif_frame_sched.sv
// Double-buffered GIF frame scheduler: sweeps image memory one word at a time,
// hands pixels to a ready/valid consumer, and toggles the active bank every FRAME_HOLD sweeps.
module gif_frame_sched #(
  parameter int DEPTH      = 2048,
  parameter int ADDR_W     = 12,
  parameter int LINE_LEN   = 64,
  parameter int FRAME_HOLD = 30
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  output logic              mem_rd,
  output logic [ADDR_W-1:0] mem_addr,
  input  logic [23:0]       mem_rdata,
  output logic [11:0]       pix_data,
  output logic              pix_valid,
  input  logic              pix_ready,
  output logic              pix_sof,
  output logic              pix_eol,
  output logic              frame_sel,
  output logic              busy
);

  localparam int CW = (FRAME_HOLD > 1) ? $clog2(FRAME_HOLD) : 1;
  localparam logic [ADDR_W-1:0] ADDR_LAST = ADDR_W'(DEPTH - 1);
  localparam logic [CW-1:0]     SW_LAST   = CW'(FRAME_HOLD - 1);

  typedef enum logic [1:0] {IDLE, FETCH, HOLD, FRAME_END} state_t;

  state_t              state, state_nx;
  logic [CW-1:0]       sweep, sweep_nx;
  logic                mem_rd_nx, pix_valid_nx, pix_sof_nx, pix_eol_nx, frame_sel_nx, busy_nx;
  logic [ADDR_W-1:0]   mem_addr_nx;
  logic [11:0]         pix_data_nx;
  logic                hs;
  logic                at_eol;

  assign hs     = pix_valid & pix_ready;
  assign at_eol = (32'(mem_addr) % 32'(LINE_LEN)) == 32'(LINE_LEN - 1);

  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      sweep     <= '0;
      mem_rd    <= 1'b0;
      mem_addr  <= '0;
      pix_data  <= '0;
      pix_valid <= 1'b0;
      pix_sof   <= 1'b0;
      pix_eol   <= 1'b0;
      frame_sel <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_nx;
      sweep     <= sweep_nx;
      mem_rd    <= mem_rd_nx;
      mem_addr  <= mem_addr_nx;
      pix_data  <= pix_data_nx;
      pix_valid <= pix_valid_nx;
      pix_sof   <= pix_sof_nx;
      pix_eol   <= pix_eol_nx;
      frame_sel <= frame_sel_nx;
      busy      <= busy_nx;
    end
  end

  // en only matters at sweep boundaries, so a mid-frame drop still finishes the frame
  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:      if (en) state_nx = FETCH;
      FETCH:     state_nx = HOLD;
      HOLD:      if (hs) state_nx = (mem_addr == ADDR_LAST) ? FRAME_END : FETCH;
      FRAME_END: state_nx = en ? FETCH : IDLE;
      default:   state_nx = IDLE;
    endcase
  end

  // Every output is the registered image of a value decided here
  always_comb begin
    mem_rd_nx    = (state_nx == FETCH);
    busy_nx      = (state_nx != IDLE);
    mem_addr_nx  = mem_addr;
    pix_data_nx  = pix_data;
    pix_valid_nx = pix_valid;
    pix_sof_nx   = pix_sof;
    pix_eol_nx   = pix_eol;
    frame_sel_nx = frame_sel;
    sweep_nx     = sweep;
    unique case (state)
      FETCH: begin
        pix_data_nx  = frame_sel ? mem_rdata[11:0] : mem_rdata[23:12];
        pix_valid_nx = 1'b1;
        pix_sof_nx   = (mem_addr == '0);
        pix_eol_nx   = at_eol;
      end
      HOLD: if (hs) begin
        pix_valid_nx = 1'b0;
        pix_sof_nx   = 1'b0;
        pix_eol_nx   = 1'b0;
        mem_addr_nx  = (mem_addr == ADDR_LAST) ? '0 : mem_addr + ADDR_W'(1);
      end
      FRAME_END: begin
        if (sweep == SW_LAST) begin
          sweep_nx     = '0;
          frame_sel_nx = ~frame_sel;
        end else begin
          sweep_nx = sweep + CW'(1);
        end
      end
      default: ;
    endcase
  end

endmodule
